// File: rtl/mcash_arb_pkg.sv
// Shared helpers for the arbiter return path: index/count widths and the
// grant-vector-to-index conversion used when recording a grant.
package mcash_arb_pkg;

  // Widest grant vector the index conversion accepts.
  localparam int unsigned MAX_N = 32;

  function automatic int unsigned calc_iw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Lowest set bit wins, so a malformed multi-hot grant still maps to one requester.
  function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_resp_router_if.sv
// Request-tracking and response-steering signals between the shared downstream
// port, the arbiter and the N requester response ports.
interface rr_resp_router_if #(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  grant_i;
  logic          fire_i;
  logic          stall_o;
  logic          resp_valid_i;
  logic          resp_ready_o;
  logic [DW-1:0] resp_data_i;
  logic [N-1:0]  resp_valid_o;
  logic [N-1:0]  resp_ready_i;
  logic [DW-1:0] resp_data_o;
  logic [CW-1:0] outstanding_o;
  logic          err_o;

  modport slave (
    input  grant_i, fire_i, resp_valid_i, resp_data_i, resp_ready_i,
    output stall_o, resp_ready_o, resp_valid_o, resp_data_o, outstanding_o, err_o
  );

  modport master (
    output grant_i, fire_i, resp_valid_i, resp_data_i, resp_ready_i,
    input  stall_o, resp_ready_o, resp_valid_o, resp_data_o, outstanding_o, err_o
  );
endinterface

// File: rtl/idx_fifo.sv
// Small synchronous FIFO holding requester indices of outstanding transactions.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module idx_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rr_resp_router.sv
// Routes in-order downstream responses back to the requester that issued each
// transaction, using a FIFO of recorded grant indices.
module rr_resp_router
  import mcash_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  rr_resp_router_if.slave  bus
);
  localparam int IW = calc_iw(N);
  localparam int CW = calc_cw(DEPTH);

  logic [MAX_N-1:0] grant_ext;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             grant_none;
  logic             grant_multi;
  logic             err_q;
  logic [CW-1:0]    count;

  always_comb begin
    grant_ext        = '0;
    grant_ext[N-1:0] = bus.grant_i;
  end

  assign wr_idx      = IW'(onehot_to_idx(grant_ext));
  assign grant_none  = (bus.grant_i == '0);
  assign grant_multi = |(bus.grant_i & (bus.grant_i - N'(1)));

  // No same-cycle lookahead: a pop never frees room for a push while full.
  assign push = bus.fire_i && !grant_none && !full;
  assign pop  = bus.resp_valid_i && bus.resp_ready_o;

  idx_fifo #(.W(IW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_idx),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_comb begin
    bus.resp_valid_o = '0;
    for (int k = 0; k < N; k++) begin
      bus.resp_valid_o[k] = bus.resp_valid_i && !empty && (head == IW'(k));
    end
  end

  assign bus.resp_ready_o  = !empty && bus.resp_ready_i[head];
  assign bus.resp_data_o   = bus.resp_data_i;
  assign bus.stall_o       = full;
  assign bus.outstanding_o = count;
  assign bus.err_o         = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (bus.fire_i && (grant_none || grant_multi || full)) begin
      err_q <= 1'b1;
    end
  end
endmodule
